sramlike_axi_bridge: RTL and testbench
======================================

Name: sramlike_axi_bridge

Overview:
Downstream neighbour of the instruction/data SRAM-like interfaces: it accepts the inst and data SRAM-like request streams and issues them as single-beat AXI3 transactions on one master port. At most one transaction is outstanding at a time. The bridge answers with addr_ok/data_ok handshakes and sits between the CPU core's SRAM-like adapters and the SoC AXI crossbar.

Parameters:
DATA_ID, 4'd1, AXI ID used for data-side transactions
INST_ID, 4'd0, AXI ID used for instruction-side transactions

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset; rst=0 resets all state
inst_req  input  1  instruction read request
inst_size  input  2  0=byte,1=half,2=word
inst_addr  input  32  instruction address
inst_rdata  output  32  read data, valid with inst_data_ok
inst_addr_ok  output  1  request accepted this cycle
inst_data_ok  output  1  read data returned this cycle
data_req  input  1  data request
data_wr  input  1  1=write, 0=read
data_size  input  2  0=byte,1=half,2=word
data_addr  input  32  data address
data_wdata  input  32  write data
data_rdata  output  32  read data, valid with data_data_ok
data_addr_ok  output  1  request accepted this cycle
data_data_ok  output  1  read data returned / write acknowledged
arid  output  4  read ID
araddr  output  32  read address
arsize  output  3  {1'b0, size}
arvalid  output  1  read address valid
arready  input  1  read address ready
rid  input  4  read response ID (checked only in assertions)
rdata  input  32  read data
rvalid  input  1  read data valid
rready  output  1  read data ready
awid  output  4  write ID (always DATA_ID)
awaddr  output  32  write address
awsize  output  3  {1'b0, size}
awvalid  output  1  write address valid
awready  input  1  write address ready
wdata  output  32  write data
wstrb  output  4  byte strobes
wvalid  output  1  write data valid
wready  input  1  write data ready
bvalid  input  1  write response valid
bready  output  1  write response ready

Behaviour:
- Fixed AXI fields are tied at top level and are not ports: len=0, burst=INCR, lock/cache/prot=0, wid=DATA_ID, wlast=1.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset state is IDLE. On reset all valid/ready and ok outputs are 0, and the latched address, size, wdata and rdata registers are 0.
- Acceptance happens in IDLE only. data_req has priority over inst_req. The granted side gets a combinational addr_ok=1 in that same cycle, and the other side's addr_ok=0. Address, size, wr, wdata and the source flag are latched on acceptance.
- Read path: IDLE -> RD_ADDR, with arvalid=1 from the next cycle until arready. Then RD_DATA with rready=1. On rvalid the bridge latches rdata, pulses the source's data_ok for exactly 1 cycle (the cycle after the R handshake, registered) and returns to IDLE.
- Write path (data only): IDLE -> WR_REQ, with awvalid and wvalid raised together. Each valid drops independently once its own handshake completes, and the FSM moves to WR_RESP when both are done (same cycle or different cycles). In WR_RESP bready=1. On bvalid the bridge pulses data_data_ok for 1 cycle and returns to IDLE. bresp is ignored.
- wstrb: size0 gives 4'b0001 << addr[1:0]; size1 gives addr[1] ? 4'b1100 : 4'b0011; size2/3 gives 4'b1111. wdata is passed unshifted, because the core pre-aligns it.
- Minimum latency from addr_ok to data_ok with ready slaves: read = 3 cycles, write = 3 cycles.
- New requests are not accepted while data_ok is pulsing. The earliest next addr_ok is 1 cycle after data_ok, so IDLE is re-entered registered.
- inst_rdata and data_rdata both come from the shared rdata latch. Each is meaningful only with its own data_ok.
- Asynchronous reset mid-transaction: the FSM returns to IDLE immediately and any in-flight AXI transaction is abandoned. The system guarantees the slave is reset with it.
- A req held with no acceptance gets no response. Requests must be held until addr_ok.

Decomposition:
- Shared package holds the state encoding enum, AXI burst/size constants, and the ID defaults.
- One natural sub-module is sramlike_wstrb_gen: combinational size/addr to wstrb decode, reused by the uncached store path.

Test Plan:
- Inst read: inst_req=1, addr=0xBFC00000, size=2; arready and rvalid come 1 cycle after asserted; rdata=0x3C1D0000 -> inst_addr_ok in cycle 0, araddr=0xBFC00000, arid=0, inst_data_ok 1-cycle pulse, inst_rdata=0x3C1D0000.
- Simultaneous requests: inst_req=1 and data_req=1 read at 0x80001000 in the same cycle -> data_addr_ok=1, inst_addr_ok=0; data serviced first (arid=1); inst accepted 1 cycle after data_data_ok.
- Byte store: data_wr=1, size=0, addr=0x80000003, wdata=0xAB000000 -> awaddr=0x80000003, awsize=0, wstrb=4'b1000; data_data_ok pulses once after bvalid.
- Skewed write handshake: wready arrives 4 cycles after awready -> awvalid drops after its handshake, wvalid stays high until wready, bready asserts only after both handshakes.
- Back-pressure: arready held at 0 for 10 cycles -> arvalid and araddr stay stable, no addr_ok for other requests, no data_ok until the R handshake.
- Reset mid-read: rst=0 while in RD_DATA -> rready, arvalid and all ok outputs go to 0 immediately; after release the next inst_req is accepted in IDLE.

Source files
------------

// File: rtl/sramlike_axi_bridge_pkg.sv
// Shared encodings for the SRAM-like to AXI3 bridge.
// State codes, AXI constants, default IDs and the latched request bundle.
package sramlike_axi_bridge_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_ADDR = 3'd1;
   localparam logic [2:0] S_RD_DATA = 3'd2;
   localparam logic [2:0] S_WR_REQ  = 3'd3;
   localparam logic [2:0] S_WR_RESP = 3'd4;

   localparam logic [3:0] DEF_INST_ID = 4'd0;
   localparam logic [3:0] DEF_DATA_ID = 4'd1;

   localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        wr;
      logic [31:0] wdata;
      logic        src_data;
   } req_t;

endpackage

// File: rtl/sramlike_wstrb_gen.sv
// Byte-lane strobe decode from transfer size and low address bits.
// Write data is already lane-aligned by the core, so only the strobe moves.
module sramlike_wstrb_gen
   import sramlike_axi_bridge_pkg::*;
(
   input  logic [1:0] i_size,
   input  logic [1:0] i_addr_lo,
   output logic [3:0] o_wstrb
);

   always_comb begin
      o_wstrb = 4'b1111;
      case (i_size)
         SZ_BYTE: o_wstrb = 4'b0001 << i_addr_lo;
         SZ_HALF: o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
         default: o_wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/sramlike_axi_bridge.sv
// Inst/data SRAM-like request streams onto one AXI3 master port.
// Single-beat transfers, one outstanding transaction, data side wins ties.
module sramlike_axi_bridge
   import sramlike_axi_bridge_pkg::*;
#(
   parameter logic [3:0] DATA_ID = DEF_DATA_ID,
   parameter logic [3:0] INST_ID = DEF_INST_ID
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [2:0]  arsize,
   output logic        arvalid,
   input  logic        arready,
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic        rvalid,
   output logic        rready,
   output logic [3:0]  awid,
   output logic [31:0] awaddr,
   output logic [2:0]  awsize,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic        bvalid,
   output logic        bready
);

   logic [2:0]  r_state;
   req_t        r_req;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_inst_dok;
   logic        r_data_dok;
   logic [31:0] r_rdata;

   logic w_idle;
   logic w_take_data;
   logic w_take_inst;
   logic w_r_hs;
   logic w_b_hs;
   logic w_aw_done;
   logic w_w_done;

   // The data_ok cycle blocks acceptance so the next grant lands one cycle later
   assign w_idle      = rst && (r_state == S_IDLE) && !r_inst_dok && !r_data_dok;
   assign w_take_data = w_idle && data_req;
   assign w_take_inst = w_idle && inst_req && !data_req;
   assign w_r_hs      = (r_state == S_RD_DATA) && rvalid;
   assign w_b_hs      = (r_state == S_WR_RESP) && bvalid;
   assign w_aw_done   = !r_awvalid || awready;
   assign w_w_done    = !r_wvalid || wready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_req      <= '0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_inst_dok <= 1'b0;
         r_data_dok <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_inst_dok <= w_r_hs && !r_req.src_data;
         r_data_dok <= (w_r_hs && r_req.src_data) || w_b_hs;
         case (r_state)
            S_IDLE: begin
               if (w_take_data) begin
                  r_req     <= '{addr: data_addr, size: data_size, wr: data_wr,
                                 wdata: data_wdata, src_data: 1'b1};
                  r_awvalid <= data_wr;
                  r_wvalid  <= data_wr;
                  r_state   <= data_wr ? S_WR_REQ : S_RD_ADDR;
               end else if (w_take_inst) begin
                  r_req   <= '{addr: inst_addr, size: inst_size, wr: 1'b0,
                               wdata: 32'd0, src_data: 1'b0};
                  r_state <= S_RD_ADDR;
               end
            end
            S_RD_ADDR: begin
               if (arready) r_state <= S_RD_DATA;
            end
            S_RD_DATA: begin
               if (rvalid) begin
                  r_rdata <= rdata;
                  r_state <= S_IDLE;
               end
            end
            S_WR_REQ: begin
               if (awready) r_awvalid <= 1'b0;
               if (wready)  r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) r_state <= S_WR_RESP;
            end
            S_WR_RESP: begin
               if (bvalid) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   sramlike_wstrb_gen u_wstrb (
      .i_size    (r_req.size),
      .i_addr_lo (r_req.addr[1:0]),
      .o_wstrb   (wstrb)
   );

   assign inst_addr_ok = w_take_inst;
   assign data_addr_ok = w_take_data;
   assign inst_data_ok = r_inst_dok;
   assign data_data_ok = r_data_dok;
   assign inst_rdata   = r_rdata;
   assign data_rdata   = r_rdata;

   assign arid    = r_req.src_data ? DATA_ID : INST_ID;
   assign araddr  = r_req.addr;
   assign arsize  = {1'b0, r_req.size};
   assign arvalid = (r_state == S_RD_ADDR);
   assign rready  = (r_state == S_RD_DATA);

   assign awid    = DATA_ID;
   assign awaddr  = r_req.addr;
   assign awsize  = {1'b0, r_req.size};
   assign awvalid = r_awvalid;
   assign wdata   = r_req.wdata;
   assign wvalid  = r_wvalid;
   assign bready  = (r_state == S_WR_RESP);

   // Responses must come back tagged with the ID of the read in flight
   a_rid_match: assert property (@(posedge clk) disable iff (!rst)
      w_r_hs |-> (rid == arid));

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Directed plus randomized bench for the SRAM-like to AXI3 bridge.
// The bench plays both the core and a single-beat AXI slave with a word memory.
module tb_sramlike_axi_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [31:0] data_rdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [2:0]  awsize;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem [int unsigned];

   always #5 clk = ~clk;

   sramlike_axi_bridge dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
      .arready(arready), .rid(rid), .rdata(rdata), .rvalid(rvalid),
      .rready(rready), .awid(awid), .awaddr(awaddr), .awsize(awsize),
      .awvalid(awvalid), .awready(awready), .wdata(wdata), .wstrb(wstrb),
      .wvalid(wvalid), .wready(wready), .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Lanes covered by an access: naturally aligned group of 2**size bytes
   function automatic logic [3:0] exp_strb(input logic [31:0] a,
                                           input int sz);
      int nb;
      int off;
      nb  = (sz >= 2) ? 4 : (1 << sz);
      off = (int'(a % 4) / nb) * nb;
      return 4'(((1 << nb) - 1) << off);
   endfunction

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      int unsigned key;
      key = a >> 2;
      if (mem.exists(key)) return mem[key];
      return 32'hD0000000 ^ a;
   endfunction

   task automatic mem_wr(input logic [31:0] a, input int sz,
                         input logic [31:0] wd);
      logic [31:0] w;
      logic [3:0]  s;
      w = mem_rd(a);
      s = exp_strb(a, sz);
      for (int b = 0; b < 4; b++)
         if (s[b]) w[8*b +: 8] = wd[8*b +: 8];
      mem[a >> 2] = w;
   endtask

   task automatic set_req(input bit d, input bit wr, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] wd);
      if (d) begin
         data_req = 1'b1; data_wr = wr; data_addr = a;
         data_size = sz; data_wdata = wd;
      end else begin
         inst_req = 1'b1; inst_addr = a; inst_size = sz;
      end
   endtask

   // Grant check in the request cycle; the side's fields are then scrambled
   task automatic accept(input bit d, input string tag);
      @(negedge clk);
      chk({tag, "_aok"},   d ? data_addr_ok : inst_addr_ok, 1);
      chk({tag, "_other"}, d ? inst_addr_ok : data_addr_ok, 0);
      @(posedge clk);
      #1;
      if (d) begin
         data_req = 1'b0; data_addr = $urandom; data_wdata = $urandom;
         data_size = 2'($urandom); data_wr = 1'($urandom);
      end else begin
         inst_req = 1'b0; inst_addr = $urandom; inst_size = 2'($urandom);
      end
   endtask

   task automatic rd_body(input bit d, input logic [31:0] a,
                          input logic [1:0] sz, input int ard, input int rd,
                          input logic [31:0] val);
      for (int k = 0; k <= ard; k++) begin
         arready = (k == ard);
         @(negedge clk);
         chk("arvalid", arvalid, 1);
         chk("araddr", araddr, a);
         chk("arid", arid, d ? 32'd1 : 32'd0);
         chk("arsize", arsize, {1'b0, sz});
         chk("oks_ar", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
         @(posedge clk);
         #1;
      end
      arready = 1'b0;
      for (int k = 0; k <= rd; k++) begin
         rvalid = (k == rd);
         rdata  = (k == rd) ? val : $urandom;
         rid    = d ? 4'd1 : 4'd0;
         @(negedge clk);
         chk("rready", rready, 1);
         chk("arvalid_off", arvalid, 0);
         chk("oks_r", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
         @(posedge clk);
         #1;
      end
      rvalid = 1'b0;
      rdata  = $urandom;
      @(negedge clk);
      chk("rd_dok", d ? data_data_ok : inst_data_ok, 1);
      chk("rd_dok_other", d ? inst_data_ok : data_data_ok, 0);
      chk("rd_rdata", d ? data_rdata : inst_rdata, val);
      chk("rd_aok_block", {inst_addr_ok, data_addr_ok}, 0);
      chk("rready_off", rready, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic wr_body(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input int awd, input int wdl,
                          input int bd);
      bit aw_done = 0;
      bit w_done  = 0;
      int c = 0;
      while (!(aw_done && w_done)) begin
         awready = (c >= awd);
         wready  = (c >= wdl);
         @(negedge clk);
         chk("awvalid", awvalid, !aw_done);
         chk("wvalid", wvalid, !w_done);
         chk("bready_early", bready, 0);
         chk("awaddr", awaddr, a);
         chk("awsize", awsize, {1'b0, sz});
         chk("awid", awid, 1);
         chk("wstrb", wstrb, exp_strb(a, sz));
         chk("wdata", wdata, wd);
         chk("oks_w", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
         @(posedge clk);
         if (awready) aw_done = 1;
         if (wready)  w_done  = 1;
         #1;
         c++;
      end
      awready = 1'b0;
      wready  = 1'b0;
      for (int k = 0; k <= bd; k++) begin
         bvalid = (k == bd);
         @(negedge clk);
         chk("bready", bready, 1);
         chk("aw_w_off", {awvalid, wvalid}, 0);
         chk("oks_b", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
         @(posedge clk);
         #1;
      end
      bvalid = 1'b0;
      @(negedge clk);
      chk("wr_dok", data_data_ok, 1);
      chk("wr_dok_inst", inst_data_ok, 0);
      chk("wr_aok_block", {inst_addr_ok, data_addr_ok}, 0);
      @(posedge clk);
      #1;
      mem_wr(a, int'(sz), wd);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      chk("idle_oks", {inst_data_ok, data_data_ok}, 0);
      chk("idle_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] v;
      logic [1:0]  sz;
      bit          d;
      bit          wr;

      rst = 1'b0;
      inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h1234_5678;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
      data_addr = '0; data_wdata = '0;
      arready = 0; rid = 0; rdata = 0; rvalid = 0;
      awready = 0; wready = 0; bvalid = 0;

      // reset state, including a request held during reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
      chk("rst_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
      chk("rst_araddr", araddr, 0);
      chk("rst_wdata", wdata, 0);
      chk("rst_rdata", inst_rdata, 0);
      inst_req = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      idle_cycle();

      // instruction fetch from the boot vector
      set_req(0, 0, 32'hBFC0_0000, 2'd2, 0);
      accept(0, "inst_rd");
      rd_body(0, 32'hBFC0_0000, 2'd2, 1, 1, 32'h3C1D_0000);
      idle_cycle();

      // same-cycle requests: data first, inst one cycle after data_ok
      set_req(1, 0, 32'h8000_1000, 2'd2, 0);
      set_req(0, 0, 32'hBFC0_0004, 2'd2, 0);
      accept(1, "both_data");
      rd_body(1, 32'h8000_1000, 2'd2, 0, 0, mem_rd(32'h8000_1000));
      accept(0, "both_inst");
      rd_body(0, 32'hBFC0_0004, 2'd2, 0, 0, mem_rd(32'hBFC0_0004));
      idle_cycle();

      // byte store to the top lane
      set_req(1, 1, 32'h8000_0003, 2'd0, 32'hAB00_0000);
      accept(1, "byte_st");
      wr_body(32'h8000_0003, 2'd0, 32'hAB00_0000, 0, 0, 0);
      idle_cycle();

      // W handshake four cycles behind AW
      set_req(1, 1, 32'h8000_0010, 2'd1, 32'h0000_BEEF);
      accept(1, "skew_st");
      wr_body(32'h8000_0010, 2'd1, 32'h0000_BEEF, 0, 4, 1);
      idle_cycle();

      // arready stalled while a data request waits
      set_req(0, 0, 32'h0000_1000, 2'd2, 0);
      accept(0, "bp_inst");
      set_req(1, 0, 32'h8000_0003, 2'd0, 0);
      rd_body(0, 32'h0000_1000, 2'd2, 10, 2, mem_rd(32'h0000_1000));
      accept(1, "bp_data");
      rd_body(1, 32'h8000_0003, 2'd0, 0, 0, mem_rd(32'h8000_0003));
      idle_cycle();

      // reset while waiting for read data
      set_req(0, 0, 32'hBFC0_0010, 2'd2, 0);
      accept(0, "rst_rd");
      arready = 1'b1;
      @(posedge clk);
      #1;
      arready = 1'b0;
      set_req(0, 0, 32'hBFC0_0020, 2'd2, 0);
      @(negedge clk);
      chk("rst_rd_rready", rready, 1);
      chk("rst_rd_aok", inst_addr_ok, 0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
      chk("rst_mid_oks", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_rel_aok", inst_addr_ok, 1);
      @(posedge clk);
      #1;
      inst_req = 1'b0;
      rd_body(0, 32'hBFC0_0020, 2'd2, 0, 0, mem_rd(32'hBFC0_0020));
      idle_cycle();

      // random mix of reads and writes over a small address window
      for (int t = 0; t < 24; t++) begin
         d  = 1'($urandom);
         wr = d && 1'($urandom);
         a  = 32'h8000_0000 | ($urandom & 32'h3F);
         sz = 2'($urandom);
         v  = $urandom;
         set_req(d, wr, a, sz, v);
         accept(d, "rnd");
         if (wr)
            wr_body(a, sz, v, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3));
         else
            rd_body(d, a, sz, $urandom_range(0, 3), $urandom_range(0, 3),
                    mem_rd(a));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
